// File: rtl/trx_sequencer.sv
// trx_sequencer: SMI/LVDS direction and flow-control sequencer (idle/RX/TX via flush, drain, guard).
// Define DREQ_HYST_EN to enable hysteresis on the SMI DREQ line; the default build uses plain compares.
module trx_sequencer #(
  parameter int LEVEL_W      = 10,
  parameter int RX_DREQ_THR  = 3,
  parameter int TX_DREQ_LOW  = 500,
  parameter int TX_DREQ_HIGH = 508,
  parameter int FLUSH_CYCLES = 4,
  parameter int GUARD_CYCLES = 16,
  parameter int DRAIN_MAX    = 1023
) (
  input  logic               i_sys_clk,
  input  logic               i_reset,
  input  logic [1:0]         i_mode_req,
  input  logic               i_mode_load,
  input  logic [LEVEL_W-1:0] i_rx_level,
  input  logic [LEVEL_W-1:0] i_tx_level,
  input  logic               i_rx_empty,
  input  logic               i_tx_empty,
  output logic               o_trx_state_tx,
  output logic               o_smi_dreq,
  output logic               o_fifo_flush,
  output logic               o_rx_enable,
  output logic               o_tx_enable,
  output logic               o_busy,
  output logic [2:0]         o_state,
  output logic               o_drain_timeout
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_RX       = 3'd2,
    S_RX_DRAIN = 3'd3,
    S_TX       = 3'd4,
    S_TX_DRAIN = 3'd5,
    S_GUARD    = 3'd6
  } state_t;

  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_RX   = 2'b01;
  localparam logic [1:0] M_TX   = 2'b10;

  // One down-counter serves every timed phase; it is loaded with (length - 1).
  localparam int CNT_MAX_FG = (FLUSH_CYCLES > GUARD_CYCLES) ? FLUSH_CYCLES : GUARD_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_FG > DRAIN_MAX) ? CNT_MAX_FG : DRAIN_MAX;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_MAX - 1);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       target;
  logic [1:0]       target_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timeout_nxt;
  logic             dreq_nxt;

  function automatic logic [1:0] mode_norm(input logic [1:0] req);
    return (req == 2'b11) ? M_IDLE : req;
  endfunction

  function automatic logic rx_above(input logic [LEVEL_W-1:0] lvl);
    return 32'(lvl) > $unsigned(RX_DREQ_THR);
  endfunction

  function automatic logic tx_below(input logic [LEVEL_W-1:0] lvl);
    return 32'(lvl) < $unsigned(TX_DREQ_LOW);
  endfunction

`ifdef DREQ_HYST_EN
  function automatic logic tx_release(input logic [LEVEL_W-1:0] lvl);
    return 32'(lvl) >= $unsigned(TX_DREQ_HIGH);
  endfunction
`endif

  // A load strobe takes effect immediately for the mode-following states (IDLE/RX/TX);
  // end-of-phase decisions (FLUSH, GUARD) look at the registered target.
  assign target_nxt = i_mode_load ? mode_norm(i_mode_req) : target;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (cnt != '0) ? (cnt - CNT_W'(1)) : cnt;
    timeout_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (target_nxt != M_IDLE) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        if (cnt == '0) begin
          case (target)
            M_RX:    state_nxt = S_RX;
            M_TX:    state_nxt = S_TX;
            default: state_nxt = S_IDLE;
          endcase
        end
      end
      S_RX: begin
        if (target_nxt != M_RX) begin
          state_nxt = S_RX_DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end
      end
      S_RX_DRAIN: begin
        if (i_rx_empty) begin
          state_nxt = S_GUARD;
          cnt_nxt   = GUARD_LOAD;
        end else if (cnt == '0) begin
          state_nxt   = S_GUARD;
          cnt_nxt     = GUARD_LOAD;
          timeout_nxt = 1'b1;
        end
      end
      S_TX: begin
        if (target_nxt != M_TX) begin
          state_nxt = S_TX_DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end
      end
      S_TX_DRAIN: begin
        if (i_tx_empty) begin
          state_nxt = S_GUARD;
          cnt_nxt   = GUARD_LOAD;
        end else if (cnt == '0) begin
          state_nxt   = S_GUARD;
          cnt_nxt     = GUARD_LOAD;
          timeout_nxt = 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt == '0) begin
          if (target == M_IDLE) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_FLUSH;
            cnt_nxt   = FLUSH_LOAD;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // DREQ is computed against the next state so it drops in the very cycle a phase ends.
  always_comb begin
    dreq_nxt = 1'b0;
    case (state_nxt)
`ifdef DREQ_HYST_EN
      S_RX:       dreq_nxt = rx_above(i_rx_level) ? 1'b1 : (i_rx_empty ? 1'b0 : o_smi_dreq);
      S_TX:       dreq_nxt = tx_below(i_tx_level) ? 1'b1 : (tx_release(i_tx_level) ? 1'b0 : o_smi_dreq);
`else
      S_RX:       dreq_nxt = rx_above(i_rx_level);
      S_TX:       dreq_nxt = tx_below(i_tx_level);
`endif
      S_RX_DRAIN: dreq_nxt = !i_rx_empty;
      default:    dreq_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state           <= S_IDLE;
      target          <= M_IDLE;
      cnt             <= '0;
      o_trx_state_tx  <= 1'b1;
      o_smi_dreq      <= 1'b0;
      o_fifo_flush    <= 1'b0;
      o_rx_enable     <= 1'b0;
      o_tx_enable     <= 1'b0;
      o_busy          <= 1'b0;
      o_state         <= 3'd0;
      o_drain_timeout <= 1'b0;
    end else begin
      state           <= state_nxt;
      target          <= target_nxt;
      cnt             <= cnt_nxt;
      o_trx_state_tx  <= !((state_nxt == S_RX) || (state_nxt == S_RX_DRAIN));
      o_smi_dreq      <= dreq_nxt;
      o_fifo_flush    <= (state_nxt == S_FLUSH);
      o_rx_enable     <= (state_nxt == S_RX);
      o_tx_enable     <= (state_nxt == S_TX) || (state_nxt == S_TX_DRAIN);
      o_busy          <= !((state_nxt == S_IDLE) || (state_nxt == S_RX) || (state_nxt == S_TX));
      o_state         <= state_nxt;
      o_drain_timeout <= timeout_nxt;
    end
  end

endmodule

// File: doc/trx_sequencer.md
# trx_sequencer

Direction and flow-control sequencer for the SMI/LVDS sample path. It takes mode requests (idle/RX/TX) from the system control register block and walks the datapath through flush, run, drain and bus-turnaround phases. It owns the SMI bus direction (`o_trx_state_tx`), the FIFO flush pulse and the SMI DREQ line. It replaces the purely combinational direction/DREQ assignment at top level with a stateful, glitch-free controller.

## Interface
Parameters:
- `LEVEL_W`, 10: width of the FIFO filling-level inputs.
- `RX_DREQ_THR`, 3: RX DREQ asserts when the RX level exceeds this value.
- `TX_DREQ_LOW`, 500: TX DREQ asserts when the TX level is below this value.
- `TX_DREQ_HIGH`, 508: TX DREQ release level; used only when `DREQ_HYST_EN` is defined.
- `FLUSH_CYCLES`, 4: length of the FIFO flush pulse, in cycles (≥1).
- `GUARD_CYCLES`, 16: bus-turnaround guard time, in cycles (≥1).
- `DRAIN_MAX`, 1023: drain timeout, in cycles (≥1).

Ports:
- `i_sys_clk`, in, 1: system clock; the only clock.
- `i_reset`, in, 1: reset, synchronous, active-high.
- `i_mode_req`, in, 2: requested mode. 00 = idle, 01 = RX, 10 = TX, 11 = treated as idle.
- `i_mode_load`, in, 1: single-cycle strobe that latches `i_mode_req` into the target register.
- `i_rx_level`, in, `LEVEL_W`: RX FIFO filling level, already in the `i_sys_clk` domain.
- `i_tx_level`, in, `LEVEL_W`: TX FIFO filling level, already in the `i_sys_clk` domain.
- `i_rx_empty`, in, 1: RX FIFO empty.
- `i_tx_empty`, in, 1: TX FIFO empty.
- `o_trx_state_tx`, out, 1: 1 = SMI bus tri-stated (TX/safe); 0 = FPGA drives the bus.
- `o_smi_dreq`, out, 1: SMI DMA request.
- `o_fifo_flush`, out, 1: FIFO reset request, active-high.
- `o_rx_enable`, out, 1: enables the RX framer push.
- `o_tx_enable`, out, 1: enables the LVDS TX FIFO pull.
- `o_busy`, out, 1: high in every state except IDLE, RX and TX.
- `o_state`, out, 3: current state encoding, for status readback.
- `o_drain_timeout`, out, 1: one-cycle pulse when a drain phase exits on timeout.

## Operation
State encodings:
- IDLE = 0, FLUSH = 1, RX = 2, RX_DRAIN = 3, TX = 4, TX_DRAIN = 5, GUARD = 6.
- Encoding 7 is unreachable; it recovers to IDLE on the next cycle.

Target register:
- `i_mode_load` overwrites the target in any state.
- The target is evaluated only where a transition below names it.

State transitions:
- IDLE: target RX or TX → FLUSH.
- FLUSH: `o_fifo_flush` = 1 for `FLUSH_CYCLES` cycles.
  - Then → RX or TX according to the target at the final flush cycle.
  - If the target is idle at that point → IDLE.
- RX: target ≠ RX → RX_DRAIN. A same-mode load is ignored.
- RX_DRAIN: `o_rx_enable` = 0; the bus stays driven so the host can empty the FIFO.
  - Exits to GUARD when `i_rx_empty` = 1.
  - Also exits to GUARD after `DRAIN_MAX` cycles, with a timeout pulse.
- TX: target ≠ TX → TX_DRAIN.
- TX_DRAIN: `o_tx_enable` stays 1 and `o_smi_dreq` = 0.
  - Exits to GUARD when `i_tx_empty` = 1, or on timeout.
- GUARD: waits `GUARD_CYCLES` cycles.
  - Then → IDLE if the target is idle, otherwise → FLUSH.
  - This gives a direct RX↔TX change with a guarded turnaround.

Outputs by state:
- `o_trx_state_tx` = 0 only in RX and RX_DRAIN.
- `o_rx_enable` = 1 only in RX.
- `o_tx_enable` = 1 in TX and TX_DRAIN.

DREQ:
- RX: `o_smi_dreq` = (`i_rx_level` > `RX_DREQ_THR`).
- RX_DRAIN: `o_smi_dreq` = !`i_rx_empty`.
- TX: `o_smi_dreq` = (`i_tx_level` < `TX_DREQ_LOW`).
- All other states: 0.
- Comparisons are unsigned, at full `LEVEL_W` width.

Counters:
- A single shared down-counter, sized to the largest parameter.
- It is loaded on entry to FLUSH, RX_DRAIN, TX_DRAIN and GUARD.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE, target idle.
  - `o_trx_state_tx` = 1.
  - All other outputs = 0; `o_state` = 0.
- Mode load in IDLE at cycle N:
  - `o_state` = FLUSH and `o_fifo_flush` = 1 from N+1 through N+`FLUSH_CYCLES`.
  - RX/TX is entered at N+1+`FLUSH_CYCLES`.
- A load in RX/TX at cycle N gives the drain state at N+1.
- Drain exit condition sampled at cycle M gives GUARD at M+1.
  - On timeout, `o_drain_timeout` = 1 at M+1 only.
- GUARD entered at G gives the exit state at G+`GUARD_CYCLES`.
- DREQ reflects the level inputs with 1 cycle of latency.
  - It is forced to 0 in the same cycle the state leaves RX/TX/RX_DRAIN.
- `o_trx_state_tx` changes only on entry to or exit from the {RX, RX_DRAIN} pair, never mid-phase.
- Reset mid-operation: outputs return to reset values on the next edge.
  - No flush pulse is emitted; the FIFOs are reset by the top-level reset path.
- Simultaneous load and exit condition: the transition uses the old target, and the new target is latched.

## Configuration
- `DREQ_HYST_EN` defined:
  - TX DREQ sets when `i_tx_level` < `TX_DREQ_LOW` and clears when `i_tx_level` ≥ `TX_DREQ_HIGH`; it holds between the two levels.
  - RX DREQ sets when `i_rx_level` > `RX_DREQ_THR` and clears only when `i_rx_empty` = 1.
- `DREQ_HYST_EN` undefined: the plain compares listed under Operation apply; `TX_DREQ_HIGH` is unused.

## Test plan
- Reset, then idle for 10 cycles → `o_state` = 0, `o_trx_state_tx` = 1, all other outputs 0.
- Load RX at cycle 5 with defaults → flush high on cycles 6–9; state 2 at cycle 10; DREQ goes 1 one cycle after `i_rx_level` = 4; DREQ = 0 at `i_rx_level` = 3.
- In RX, load TX:
  - RX_DRAIN until `i_rx_empty`, then GUARD for 16 cycles.
  - `o_trx_state_tx` rises on GUARD entry.
  - Then FLUSH for 4 cycles, then TX.
  - DREQ = 1 at `i_tx_level` = 499 and 0 at 500.
- In TX, load idle with `i_tx_empty` held 0 → `o_drain_timeout` pulses after 1023 cycles, then GUARD, then IDLE.
- Loads during FLUSH of RX, then idle, then TX → TX entered; on a simultaneous load and drain exit, the turnaround still takes place.
- With `DREQ_HYST_EN`: TX levels 499→504→508→504 → DREQ 1, 1, 0, 0.
